// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle for prescaled_updown_counter: requests in, count and flags out.
// There is no valid/ready pair: en/load are level requests sampled every rising edge,
// and count/wrap/at_max/at_zero are always valid.
interface prescaled_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, up, load, load_val,
    input  count, wrap, at_max, at_zero
  );

  modport slave (
    input  en, up, load, load_val,
    output count, wrap, at_max, at_zero
  );
endinterface

// File: rtl/prescaled_updown_counter.sv
// Up/down counter over 0..MAX with wrap or saturate ends, parallel load, and a
// prescaler that advances the count once every PRESCALE enabled cycles.
module prescaled_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  prescaled_updown_counter_if.slave bus,
  output logic [31:0]             o_psc_dbg
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PSC_W-1:0] r_psc;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count_nxt;
  logic [PSC_W-1:0] w_psc_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_load_val;

  // A full-range MAX needs no clamp; the comparison would be constant.
  generate
    if (MAX_V == {WIDTH{1'b1}}) begin : g_no_clamp
      assign w_load_val = bus.load_val;
    end else begin : g_clamp
      assign w_load_val = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end
  endgenerate

  always_comb begin
    w_count_nxt = r_count;
    w_psc_nxt   = r_psc;
    w_wrap_nxt  = 1'b0;
    if (bus.load) begin
      w_count_nxt = w_load_val;
      w_psc_nxt   = '0;
    end else if (bus.en) begin
      if (r_psc != PSC_LAST) begin
        w_psc_nxt = r_psc + 1'b1;
      end else begin
        w_psc_nxt = '0;
        if (bus.up) begin
          if (r_count < MAX_V) begin
            w_count_nxt = r_count + 1'b1;
          end else if (SATURATE == 0) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          if (r_count != '0) begin
            w_count_nxt = r_count - 1'b1;
          end else if (SATURATE == 0) begin
            w_count_nxt = MAX_V;
            w_wrap_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_psc   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_psc   <= w_psc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.wrap    = r_wrap;
  assign bus.at_max  = (r_count == MAX_V);
  assign bus.at_zero = (r_count == '0);
  assign o_psc_dbg   = 32'(r_psc);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: five counter configurations share one stimulus set; each test
// checks only the instance whose parameters it targets.
module tb_prescaled_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prescaled_updown_counter_if #(.WIDTH(8)) if_a ();
  prescaled_updown_counter_if #(.WIDTH(8)) if_b ();
  prescaled_updown_counter_if #(.WIDTH(8)) if_c ();
  prescaled_updown_counter_if #(.WIDTH(8)) if_d ();
  prescaled_updown_counter_if #(.WIDTH(8)) if_e ();

  assign if_a.en = en; assign if_a.up = up; assign if_a.load = load; assign if_a.load_val = load_val;
  assign if_b.en = en; assign if_b.up = up; assign if_b.load = load; assign if_b.load_val = load_val;
  assign if_c.en = en; assign if_c.up = up; assign if_c.load = load; assign if_c.load_val = load_val;
  assign if_d.en = en; assign if_d.up = up; assign if_d.load = load; assign if_d.load_val = load_val;
  assign if_e.en = en; assign if_e.up = up; assign if_e.load = load; assign if_e.load_val = load_val;

  logic [31:0] psc_a, psc_b, psc_c, psc_d, psc_e;

  prescaled_updown_counter #(.WIDTH(8), .MAX(255), .SATURATE(0), .PRESCALE(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a), .o_psc_dbg(psc_a));
  prescaled_updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(0), .PRESCALE(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b), .o_psc_dbg(psc_b));
  prescaled_updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(1), .PRESCALE(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c), .o_psc_dbg(psc_c));
  prescaled_updown_counter #(.WIDTH(8), .MAX(255), .SATURATE(0), .PRESCALE(4))
    dut_d (.clk(clk), .rst(rst), .bus(if_d), .o_psc_dbg(psc_d));
  prescaled_updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(0), .PRESCALE(3))
    dut_e (.clk(clk), .rst(rst), .bus(if_e), .o_psc_dbg(psc_e));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'd0;
    tick(); tick();

    check("rst_count", 32'(if_a.count), 0);
    check("rst_wrap", 32'(if_a.wrap), 0);
    check("rst_at_zero", 32'(if_a.at_zero), 1);
    check("rst_at_max", 32'(if_a.at_max), 0);
    check("rst_psc", psc_d, 0);

    // Reset / hold
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("run5_count", 32'(if_a.count), 5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("hold_count", 32'(if_a.count), 5);
    rst = 1'b1; tick();
    check("rst2_count", 32'(if_a.count), 0);
    check("rst2_at_zero", 32'(if_a.at_zero), 1);

    // Modulo wrap at MAX=9
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("wrap_up_count_%0d", i), 32'(if_b.count), 32'(i % 10));
      check($sformatf("wrap_up_wrap_%0d", i), 32'(if_b.wrap), (i == 10) ? 32'd1 : 32'd0);
    end
    rst = 1'b1; tick();
    rst = 1'b0; up = 1'b0; tick();
    check("wrap_dn_count", 32'(if_b.count), 9);
    check("wrap_dn_wrap", 32'(if_b.wrap), 1);
    check("wrap_dn_at_max", 32'(if_b.at_max), 1);
    tick();
    check("wrap_dn2_count", 32'(if_b.count), 8);
    check("wrap_dn2_wrap", 32'(if_b.wrap), 0);

    // Saturate at MAX=9
    en = 1'b0; load = 1'b1; load_val = 8'd8; tick();
    check("sat_load8", 32'(if_c.count), 8);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_up_count_%0d", i), 32'(if_c.count), 9);
      check($sformatf("sat_up_at_max_%0d", i), 32'(if_c.at_max), 1);
      check($sformatf("sat_up_wrap_%0d", i), 32'(if_c.wrap), 0);
    end
    en = 1'b0; load = 1'b1; load_val = 8'd1; tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_dn_count_%0d", i), 32'(if_c.count), 0);
      check($sformatf("sat_dn_wrap_%0d", i), 32'(if_c.wrap), 0);
    end

    // Prescale by 4
    rst = 1'b1; en = 1'b0; tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("psc4_count_%0d", i), 32'(if_d.count), 32'(i / 4));
    end
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; tick(); tick();
    en = 1'b0; tick(); tick();
    check("psc4_gap_count", 32'(if_d.count), 0);
    check("psc4_gap_psc", psc_d, 2);
    en = 1'b1; tick();
    check("psc4_gap_edge3", 32'(if_d.count), 0);
    tick();
    check("psc4_gap_edge4", 32'(if_d.count), 1);
    // rst in the middle of a prescale period
    tick(); tick();
    check("psc4_mid_psc", psc_d, 2);
    rst = 1'b1; tick();
    check("psc4_rst_psc", psc_d, 0);
    check("psc4_rst_count", 32'(if_d.count), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("psc4_after_rst3", 32'(if_d.count), 0);
    tick();
    check("psc4_after_rst4", 32'(if_d.count), 1);

    // Load priority and clamp
    rst = 1'b1; tick();
    rst = 1'b0; load = 1'b1; load_val = 8'd15; en = 1'b1; up = 1'b1; tick();
    check("clamp_count", 32'(if_b.count), 9);
    check("clamp_psc", psc_b, 0);
    check("clamp_wrap", 32'(if_b.wrap), 0);
    check("clamp_psc_e", psc_e, 0);
    load_val = 8'd3; rst = 1'b1; tick();
    check("rst_over_load", 32'(if_b.count), 0);

    // Direction change mid-prescale (PRESCALE=3)
    rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'd5; tick();
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    check("dir_e1_count", 32'(if_e.count), 5);
    up = 1'b0; tick();
    check("dir_e2_count", 32'(if_e.count), 5);
    tick();
    check("dir_e3_count", 32'(if_e.count), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
